control_unit: RTL
=================

Name: control_unit

Overview:
- Hardwired Mini SRC control sequencer that drives every DataPath control strobe.
- Fetches via PC/MAR/MDR, decodes the IR opcode, and steps T0..T7 per instruction.
- Replaces the hand-coded testbench sequencing; sits beside DataPath at processor top level, sharing Clock.

Parameters:
- ST_W, 4, state register width.
- OP_W, 5, opcode field width, IR[31:27].

Ports:
- Clock  in  1  system clock, rising edge.
- Clear_n  in  1  asynchronous active-low reset.
- IR  in  32  instruction register contents from DataPath.
- CON_FF  in  1  branch condition flag from DataPath.
- Stop  in  1  halt request; sampled at T0.
- Run  out  1  high while executing, low when halted.
- PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout  out  1 each  bus drivers.
- PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin, IncPC  out  1 each  register loads.
- Read, Write  out  1 each  memory strobes.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-select controls.
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT  out  1 each  ALU op strobes.

Behaviour:
- Clock and reset:
  - Single clock. State updates on the rising edge.
  - Clear_n low asynchronously forces state T0 and Run=1.
  - All outputs are combinational from state and IR[31:27]; every strobe is 0 unless listed below, including throughout reset.
  - Reset mid-instruction aborts it; no partial strobes persist.
- States: T0..T7 and HALT.
- Fetch, common to all opcodes:
  - T0: PCout MARin IncPC Zin.
  - T1: Zlowout PCin Read MDRin.
  - T2: MDRout IRin.
- Execute per opcode. After an instruction's last listed step, the next state is T0.
  - ld(00000): T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - ldi(00001): T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout Gra Rin.
  - st(00010): T3-T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write.
  - R-type add,sub,and,or,ror,rol,shr,shra,shl (00011-01011): T3 Grb Rout Yin; T4 Grc Rout op Zin; T5 Zlowout Gra Rin.
  - addi,andi,ori (01100-01110): T3 Grb Rout Yin; T4 Cout op Zin; T5 Zlowout Gra Rin. Op is ADD, AND or OR respectively.
  - mul,div (01111,10000): T3 Gra Rout Yin; T4 Grb Rout op Zin; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg,not (10001,10010): T3 Grb Rout op Zin; T4 Zlowout Gra Rin.
  - br(10011): T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 Zlowout PCin only if CON_FF=1, otherwise an idle step.
  - jr(10100): T3 Gra Rout PCin.
  - jal(10101): T3 PCout Grb Rin (link into rb); T4 Gra Rout PCin.
  - in(10110): T3 InPortout Gra Rin.
  - out(10111): T3 Gra Rout OutPortin.
  - mfhi(11000): T3 HIout Gra Rin.
  - mflo(11001): T3 LOout Gra Rin.
  - nop(11010) and unused opcodes 11100-11111: T2 goes directly to T0.
  - halt(11011): T2 goes to HALT.
- HALT:
  - All strobes 0 and Run=0.
  - Only Clear_n exits HALT.
- Stop:
  - Sampled only at T0 entry, i.e. the cycle state would become T0.
  - If high, enter HALT instead of T0, so the in-flight instruction always completes.
  - Stop asserted during T0..T7 of an instruction takes effect at that instruction's end.
- Opcode source:
  - Opcode is read from IR in T3 onward.
  - IR changes during T2 are not decoded in T2, so T2 outputs are opcode-independent, except the next-state choice for nop/halt, which uses the IR value at the T2 clock edge.

Decomposition:
- Package control_pkg holds:
  - opcode localparams (OP_LD..OP_HALT);
  - state encodings T0..T7, HALT;
  - the ALU op-strobe index list.
- One sub-module, control_unit_decode: purely combinational, mapping (state, opcode, CON_FF) to the strobe vector.
- control_unit itself keeps the state register, next-state logic and Stop/halt handling.

Test Plan:
- ld R1,0x54(R2): IR=0x00900054 after T2 -> exactly the ld T3-T7 strobes one cycle each; fetch begins again 8 cycles after T0.
- add R3,R4,R5: IR=0x19A28000 -> T4 shows Grc Rout ADD Zin; T5 Zlowout Gra Rin; next T0 at cycle 6.
- brzr with IR=0x98000000, CON_FF=0 then CON_FF=1 -> PCin in T6 only in the CON_FF=1 run; both runs take 7 cycles.
- mul R3,R1: IR=0x79880000 -> LOin at T5 and HIin at T6, never both in the same cycle.
- halt: IR=0xD8000000 -> Run=0 from the cycle after T2 and stays 0 for 20+ cycles; all strobes 0.
- Reset and Stop:
  - Stop=1 during ld T4 -> ld completes through T7, then HALT.
  - Clear_n low at T5 of st -> immediate T0 state with all strobes 0; Write never asserted.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the Mini SRC control sequencer: opcodes, step states,
// ALU strobe indices, the strobe bundle and per-opcode decode helpers.
package control_pkg;

  localparam int ST_W = 4;
  localparam int OP_W = 5;

  typedef enum logic [ST_W-1:0] {
    T0   = 4'd0,
    T1   = 4'd1,
    T2   = 4'd2,
    T3   = 4'd3,
    T4   = 4'd4,
    T5   = 4'd5,
    T6   = 4'd6,
    T7   = 4'd7,
    HALT = 4'd8
  } state_t;

  localparam logic [OP_W-1:0] OP_LD   = 5'd0;
  localparam logic [OP_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OP_W-1:0] OP_ST   = 5'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OP_W-1:0] OP_AND  = 5'd5;
  localparam logic [OP_W-1:0] OP_OR   = 5'd6;
  localparam logic [OP_W-1:0] OP_ROR  = 5'd7;
  localparam logic [OP_W-1:0] OP_ROL  = 5'd8;
  localparam logic [OP_W-1:0] OP_SHR  = 5'd9;
  localparam logic [OP_W-1:0] OP_SHRA = 5'd10;
  localparam logic [OP_W-1:0] OP_SHL  = 5'd11;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd12;
  localparam logic [OP_W-1:0] OP_ANDI = 5'd13;
  localparam logic [OP_W-1:0] OP_ORI  = 5'd14;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd15;
  localparam logic [OP_W-1:0] OP_DIV  = 5'd16;
  localparam logic [OP_W-1:0] OP_NEG  = 5'd17;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd18;
  localparam logic [OP_W-1:0] OP_BR   = 5'd19;
  localparam logic [OP_W-1:0] OP_JR   = 5'd20;
  localparam logic [OP_W-1:0] OP_JAL  = 5'd21;
  localparam logic [OP_W-1:0] OP_IN   = 5'd22;
  localparam logic [OP_W-1:0] OP_OUT  = 5'd23;
  localparam logic [OP_W-1:0] OP_MFHI = 5'd24;
  localparam logic [OP_W-1:0] OP_MFLO = 5'd25;
  localparam logic [OP_W-1:0] OP_NOP  = 5'd26;
  localparam logic [OP_W-1:0] OP_HALT = 5'd27;

  localparam int ALU_AND  = 0;
  localparam int ALU_OR   = 1;
  localparam int ALU_ADD  = 2;
  localparam int ALU_SUB  = 3;
  localparam int ALU_MUL  = 4;
  localparam int ALU_DIV  = 5;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 8;
  localparam int ALU_ROR  = 9;
  localparam int ALU_ROL  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;
  localparam int ALU_N    = 13;

  typedef struct packed {
    logic pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, inport_out, c_out, ba_out;
    logic pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, con_in, outport_in, inc_pc;
    logic read, write;
    logic gra, grb, grc, r_in, r_out;
    logic [ALU_N-1:0] alu;
  } strobes_t;

  // Final execute step of each opcode; 2 means the instruction ends after fetch.
  function automatic logic [2:0] last_step(input logic [OP_W-1:0] op);
    logic [2:0] s;
    s = 3'd2;
    if (op == OP_LD || op == OP_ST)           s = 3'd7;
    else if (op == OP_LDI)                    s = 3'd5;
    else if (op >= OP_ADD && op <= OP_ORI)    s = 3'd5;
    else if (op == OP_MUL || op == OP_DIV)    s = 3'd6;
    else if (op == OP_NEG || op == OP_NOT)    s = 3'd4;
    else if (op == OP_BR)                     s = 3'd6;
    else if (op == OP_JAL)                    s = 3'd4;
    else if (op >= OP_JR && op <= OP_MFLO)    s = 3'd3;
    return s;
  endfunction

  function automatic logic [ALU_N-1:0] alu_onehot(input logic [OP_W-1:0] op);
    logic [ALU_N-1:0] v;
    v = '0;
    case (op)
      OP_ADD, OP_ADDI: v[ALU_ADD]  = 1'b1;
      OP_SUB:          v[ALU_SUB]  = 1'b1;
      OP_AND, OP_ANDI: v[ALU_AND]  = 1'b1;
      OP_OR, OP_ORI:   v[ALU_OR]   = 1'b1;
      OP_ROR:          v[ALU_ROR]  = 1'b1;
      OP_ROL:          v[ALU_ROL]  = 1'b1;
      OP_SHR:          v[ALU_SHR]  = 1'b1;
      OP_SHRA:         v[ALU_SHRA] = 1'b1;
      OP_SHL:          v[ALU_SHL]  = 1'b1;
      OP_MUL:          v[ALU_MUL]  = 1'b1;
      OP_DIV:          v[ALU_DIV]  = 1'b1;
      OP_NEG:          v[ALU_NEG]  = 1'b1;
      OP_NOT:          v[ALU_NOT]  = 1'b1;
      default:         v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational strobe decoder: (step, opcode, CON_FF) -> DataPath control bundle.
module control_unit_decode
  import control_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] opcode,
  input  logic            con_ff,
  output strobes_t        strobes
);

  logic is_ld, is_ldi, is_st, is_rtype, is_imm, is_muldiv, is_unary;
  logic [ALU_N-1:0] op_alu;

  assign is_ld     = (opcode == OP_LD);
  assign is_ldi    = (opcode == OP_LDI);
  assign is_st     = (opcode == OP_ST);
  assign is_rtype  = (opcode >= OP_ADD) && (opcode <= OP_SHL);
  assign is_imm    = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign op_alu    = alu_onehot(opcode);

  always_comb begin
    strobes = '0;
    case (state)
      T0: begin
        strobes.pc_out = 1'b1; strobes.mar_in = 1'b1; strobes.inc_pc = 1'b1; strobes.z_in = 1'b1;
      end
      T1: begin
        strobes.zlow_out = 1'b1; strobes.pc_in = 1'b1; strobes.read = 1'b1; strobes.mdr_in = 1'b1;
      end
      T2: begin
        strobes.mdr_out = 1'b1; strobes.ir_in = 1'b1;
      end
      T3: begin
        if (is_ld || is_ldi || is_st) begin
          strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.y_in = 1'b1;
        end else if (is_rtype || is_imm) begin
          strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.y_in = 1'b1;
        end else if (is_muldiv) begin
          strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.y_in = 1'b1;
        end else if (is_unary) begin
          strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.alu = op_alu; strobes.z_in = 1'b1;
        end else if (opcode == OP_BR) begin
          strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.con_in = 1'b1;
        end else if (opcode == OP_JR) begin
          strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.pc_in = 1'b1;
        end else if (opcode == OP_JAL) begin
          strobes.pc_out = 1'b1; strobes.grb = 1'b1; strobes.r_in = 1'b1;
        end else if (opcode == OP_IN) begin
          strobes.inport_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
        end else if (opcode == OP_OUT) begin
          strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.outport_in = 1'b1;
        end else if (opcode == OP_MFHI) begin
          strobes.hi_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
        end else if (opcode == OP_MFLO) begin
          strobes.lo_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
        end
      end
      T4: begin
        if (is_ld || is_ldi || is_st) begin
          strobes.c_out = 1'b1; strobes.alu[ALU_ADD] = 1'b1; strobes.z_in = 1'b1;
        end else if (is_rtype) begin
          strobes.grc = 1'b1; strobes.r_out = 1'b1; strobes.alu = op_alu; strobes.z_in = 1'b1;
        end else if (is_imm) begin
          strobes.c_out = 1'b1; strobes.alu = op_alu; strobes.z_in = 1'b1;
        end else if (is_muldiv) begin
          strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.alu = op_alu; strobes.z_in = 1'b1;
        end else if (is_unary) begin
          strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
        end else if (opcode == OP_BR) begin
          strobes.pc_out = 1'b1; strobes.y_in = 1'b1;
        end else if (opcode == OP_JAL) begin
          strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.pc_in = 1'b1;
        end
      end
      T5: begin
        if (is_ld || is_st) begin
          strobes.zlow_out = 1'b1; strobes.mar_in = 1'b1;
        end else if (is_ldi || is_rtype || is_imm) begin
          strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
        end else if (is_muldiv) begin
          strobes.zlow_out = 1'b1; strobes.lo_in = 1'b1;
        end else if (opcode == OP_BR) begin
          strobes.c_out = 1'b1; strobes.alu[ALU_ADD] = 1'b1; strobes.z_in = 1'b1;
        end
      end
      T6: begin
        if (is_ld) begin
          strobes.read = 1'b1; strobes.mdr_in = 1'b1;
        end else if (is_st) begin
          strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.mdr_in = 1'b1;
        end else if (is_muldiv) begin
          strobes.zhigh_out = 1'b1; strobes.hi_in = 1'b1;
        end else if (opcode == OP_BR && con_ff) begin
          strobes.zlow_out = 1'b1; strobes.pc_in = 1'b1;
        end
      end
      T7: begin
        if (is_ld) begin
          strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
        end else if (is_st) begin
          strobes.write = 1'b1;
        end
      end
      default: strobes = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Mini SRC hardwired control sequencer: step register, instruction sequencing,
// Stop/halt handling and the DataPath strobe outputs.
module control_unit
  import control_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear_n,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout,
  output logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin, IncPC,
  output logic        Read, Write,
  output logic        Gra, Grb, Grc, Rin, Rout,
  output logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT
);

  state_t          state_reg, state_next;
  logic [OP_W-1:0] opcode;
  logic [2:0]      step_last;
  logic            end_instr;
  strobes_t        strobes_raw, strobes;
  logic            unused_ir_bits;

  assign opcode         = IR[31:27];
  assign unused_ir_bits = ^IR[26:0];
  assign step_last      = last_step(opcode);

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) state_reg <= T0;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    end_instr  = 1'b0;
    case (state_reg)
      T0: state_next = T1;
      T1: state_next = T2;
      T2: begin
        if (opcode == OP_HALT)      state_next = HALT;
        else if (step_last == 3'd2) end_instr  = 1'b1;
        else                        state_next = T3;
      end
      T3, T4, T5, T6, T7: begin
        if (state_reg == T7 || state_reg[2:0] == step_last) end_instr = 1'b1;
        else state_next = state_t'(state_reg + ST_W'(1));
      end
      HALT:    state_next = HALT;
      default: state_next = T0;
    endcase
    // Stop only ever redirects the entry into T0, so instructions never truncate.
    if (end_instr) state_next = Stop ? HALT : T0;
  end

  control_unit_decode u_decode (
    .state   (state_reg),
    .opcode  (opcode),
    .con_ff  (CON_FF),
    .strobes (strobes_raw)
  );

  // Reset holds the step at T0, so fetch strobes must be suppressed while Clear_n is low.
  assign strobes = Clear_n ? strobes_raw : '0;
  assign Run     = (state_reg != HALT);

  assign PCout = strobes.pc_out;   assign Zlowout   = strobes.zlow_out;   assign Zhighout = strobes.zhigh_out;
  assign MDRout = strobes.mdr_out; assign HIout     = strobes.hi_out;     assign LOout    = strobes.lo_out;
  assign InPortout = strobes.inport_out; assign Cout = strobes.c_out;     assign BAout    = strobes.ba_out;
  assign PCin = strobes.pc_in;     assign MARin     = strobes.mar_in;     assign MDRin    = strobes.mdr_in;
  assign IRin = strobes.ir_in;     assign Yin       = strobes.y_in;       assign Zin      = strobes.z_in;
  assign HIin = strobes.hi_in;     assign LOin      = strobes.lo_in;      assign CONin    = strobes.con_in;
  assign OutPortin = strobes.outport_in; assign IncPC = strobes.inc_pc;
  assign Read = strobes.read;      assign Write     = strobes.write;
  assign Gra = strobes.gra;        assign Grb       = strobes.grb;        assign Grc      = strobes.grc;
  assign Rin = strobes.r_in;       assign Rout      = strobes.r_out;
  assign AND = strobes.alu[ALU_AND];   assign OR   = strobes.alu[ALU_OR];   assign ADD = strobes.alu[ALU_ADD];
  assign SUB = strobes.alu[ALU_SUB];   assign MUL  = strobes.alu[ALU_MUL];  assign DIV = strobes.alu[ALU_DIV];
  assign SHR = strobes.alu[ALU_SHR];   assign SHRA = strobes.alu[ALU_SHRA]; assign SHL = strobes.alu[ALU_SHL];
  assign ROR = strobes.alu[ALU_ROR];   assign ROL  = strobes.alu[ALU_ROL];  assign NEG = strobes.alu[ALU_NEG];
  assign NOT = strobes.alu[ALU_NOT];

endmodule
